// File: rtl/branch_offset_encoder_pkg.sv
// Shared widths, payload types and field packing for the branch offset encoder.
// The decoder-side sign_extend_shifter uses the same width defaults.
package branch_offset_encoder_pkg;

   localparam int DATA_WIDTH      = 16;
   localparam int FIELD_MAX_WIDTH = 12;
   localparam int FIELD_MIN_WIDTH = 8;
   localparam int SHIFT_AMOUNT    = 1;
   localparam int ERR_CNT_WIDTH   = 8;

   typedef logic [DATA_WIDTH-1:0]      addr_t;
   typedef logic [FIELD_MAX_WIDTH-1:0] field_t;
   typedef logic [ERR_CNT_WIDTH-1:0]   err_cnt_t;

   typedef enum logic {
      FIELD_BRANCH = 1'b0,
      FIELD_JUMP   = 1'b1
   } field_sel_e;

   typedef struct packed {
      addr_t pc;
      addr_t target;
      logic  jump;
   } s1_item_t;

   typedef struct packed {
      field_t field;
      logic   errAlign;
      logic   errRange;
   } s2_item_t;

   // Branch fields occupy the low bits only; the upper bits of the bus stay zero.
   function automatic field_t packField(addr_t scaled, logic jump);
      field_t result;
      if (field_sel_e'(jump) == FIELD_JUMP) begin
         result = scaled[FIELD_MAX_WIDTH-1:0];
      end else begin
         result = {{(FIELD_MAX_WIDTH-FIELD_MIN_WIDTH){1'b0}}, scaled[FIELD_MIN_WIDTH-1:0]};
      end
      return result;
   endfunction

endpackage

// File: rtl/branch_offset_encoder_if.sv
// Request/result bus of the branch offset encoder; master drives requests,
// slave (the encoder) returns the encoded field and error status.
interface branch_offset_encoder_if;
   import branch_offset_encoder_pkg::*;

   logic     in_valid;
   logic     in_ready;
   addr_t    pc;
   addr_t    target;
   logic     jump;
   logic     out_valid;
   logic     out_ready;
   field_t   field;
   logic     err_align;
   logic     err_range;
   err_cnt_t err_count;

   modport master (
      output in_valid, pc, target, jump, out_ready,
      input  in_ready, out_valid, field, err_align, err_range, err_count
   );

   modport slave (
      input  in_valid, pc, target, jump, out_ready,
      output in_ready, out_valid, field, err_align, err_range, err_count
   );

endinterface

// File: rtl/branch_offset_encoder_range_check.sv
// Decides whether a scaled displacement survives truncation to the selected
// immediate field, i.e. sign-extending the field gives back the same value.
module offset_range_check
   import branch_offset_encoder_pkg::*;
(
   input  addr_t i_scaled,
   input  logic  i_jump,
   output logic  o_fits
);

   logic w_jumpFits;
   logic w_branchFits;

   assign w_jumpFits = (i_scaled ==
      {{(DATA_WIDTH-FIELD_MAX_WIDTH){i_scaled[FIELD_MAX_WIDTH-1]}}, i_scaled[FIELD_MAX_WIDTH-1:0]});

   assign w_branchFits = (i_scaled ==
      {{(DATA_WIDTH-FIELD_MIN_WIDTH){i_scaled[FIELD_MIN_WIDTH-1]}}, i_scaled[FIELD_MIN_WIDTH-1:0]});

   assign o_fits = i_jump ? w_jumpFits : w_branchFits;

endmodule

// File: rtl/branch_offset_encoder.sv
// Two-stage encoder turning (pc, target, jump) into a PC-relative immediate
// field with alignment/range flags and a saturating error counter.
module branch_offset_encoder
   import branch_offset_encoder_pkg::*;
(
   input logic                    clk,
   input logic                    rst,
   branch_offset_encoder_if.slave bus
);

   s1_item_t r_s1Item;
   logic     r_s1Valid;
   s2_item_t r_s2Item;
   logic     r_s2Valid;
   err_cnt_t r_errCount;

   logic  w_s2Adv;
   logic  w_s1Adv;
   logic  w_inReady;
   logic  w_outAccept;
   addr_t w_disp;
   addr_t w_scaled;
   logic  w_errAlign;
   logic  w_fits;

   // Each stage advances when it is empty or the stage after it is moving,
   // so a full pipeline can accept and emit in the same cycle.
   always_comb begin
      w_s2Adv     = !r_s2Valid || bus.out_ready;
      w_s1Adv     = !r_s1Valid || w_s2Adv;
      w_inReady   = w_s1Adv && !rst;
      w_outAccept = r_s2Valid && bus.out_ready;
   end

   assign w_disp     = r_s1Item.target - r_s1Item.pc;
   assign w_scaled   = addr_t'($signed(w_disp) >>> SHIFT_AMOUNT);
   assign w_errAlign = |w_disp[SHIFT_AMOUNT-1:0];

   offset_range_check u_rangeCheck (
      .i_scaled (w_scaled),
      .i_jump   (r_s1Item.jump),
      .o_fits   (w_fits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1Valid <= 1'b0;
         r_s1Item  <= '0;
      end else if (w_s1Adv) begin
         r_s1Valid <= bus.in_valid;
         if (bus.in_valid) begin
            r_s1Item <= '{pc: bus.pc, target: bus.target, jump: bus.jump};
         end
      end
   end

   // A truncated field is still emitted alongside its error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s2Valid <= 1'b0;
         r_s2Item  <= '0;
      end else if (w_s2Adv) begin
         r_s2Valid <= r_s1Valid;
         if (r_s1Valid) begin
            r_s2Item <= '{field:    packField(w_scaled, r_s1Item.jump),
                          errAlign: w_errAlign,
                          errRange: !w_fits};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_errCount <= '0;
      end else if (w_outAccept && (r_s2Item.errAlign || r_s2Item.errRange)
                   && (r_errCount != '1)) begin
         r_errCount <= r_errCount + err_cnt_t'(1);
      end
   end

   assign bus.in_ready  = w_inReady;
   assign bus.out_valid = r_s2Valid;
   assign bus.field     = r_s2Item.field;
   assign bus.err_align = r_s2Item.errAlign;
   assign bus.err_range = r_s2Item.errRange;
   assign bus.err_count = r_errCount;

endmodule

// File: tb/tb_branch_offset_encoder.sv
// Self-checking bench for branch_offset_encoder: directed cases plus random
// traffic scored against an arithmetic model of the displacement encoding.
module tb_branch_offset_encoder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   branch_offset_encoder_if bif ();

   branch_offset_encoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   typedef struct {
      logic [11:0] field;
      bit          align;
      bit          range;
      int          disp;
      bit          jump;
   } exp_t;

   exp_t expQ[$];
   int   errors     = 0;
   int   checks     = 0;
   int   accepted   = 0;
   int   modelCount = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // Reference: signed modular displacement, halved with floor, then truncated.
   function automatic exp_t model(logic [15:0] pc, logic [15:0] tgt, bit jmp);
      exp_t e;
      int   d;
      int   s;
      d = (int'(tgt) - int'(pc)) & 32'h0000FFFF;
      if (d >= 32768) d = d - 65536;
      s = (d - (d & 1)) / 2;
      e.disp  = d;
      e.jump  = jmp;
      e.align = (d & 1) != 0;
      if (jmp) begin
         e.range = (s < -2048) || (s > 2047);
         e.field = 12'(s & 32'h00000FFF);
      end else begin
         e.range = (s < -128) || (s > 127);
         e.field = 12'(s & 32'h000000FF);
      end
      return e;
   endfunction

   // Decoder-side view: sign-extend the field and scale it back up.
   function automatic int signExtShift(logic [11:0] f, bit jmp);
      int v;
      if (jmp) v = (int'(f) >= 2048) ? int'(f) - 4096 : int'(f);
      else     v = (int'(f[7:0]) >= 128) ? int'(f[7:0]) - 256 : int'(f[7:0]);
      return (v * 2) & 32'h0000FFFF;
   endfunction

   task automatic step();
      exp_t e;
      @(negedge clk);
      if (rst) begin
         expQ.delete();
         modelCount = 0;
      end else begin
         if (bif.out_valid && bif.out_ready) begin
            if (expQ.size() == 0) begin
               checkOutput("spurious_out", 32'd1, 32'd0);
            end else begin
               e = expQ.pop_front();
               checkOutput("sb_field", bif.field, e.field);
               checkOutput("sb_align", bif.err_align, e.align);
               checkOutput("sb_range", bif.err_range, e.range);
               if (!e.align && !e.range)
                  checkOutput("roundtrip", signExtShift(bif.field, e.jump), e.disp & 32'h0000FFFF);
               if ((e.align || e.range) && modelCount < 255) modelCount++;
            end
         end
         if (bif.in_valid && bif.in_ready) begin
            expQ.push_back(model(bif.pc, bif.target, bif.jump));
            accepted++;
         end
      end
      @(posedge clk);
      #1;
      checkOutput("err_count", bif.err_count, modelCount);
   endtask

   task automatic applyStimulus(input logic [15:0] pc, input logic [15:0] tgt,
                                input bit jmp, input bit randReady);
      int n;
      bit done;
      n = accepted;
      done = 1'b0;
      bif.pc       = pc;
      bif.target   = tgt;
      bif.jump     = jmp;
      bif.in_valid = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         if (randReady) bif.out_ready = ($urandom_range(0, 3) != 0);
         step();
         done = (accepted != n);
      end
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      for (int k = 0; k < 50 && expQ.size() > 0; k++) step();
      checkOutput("drain_empty", expQ.size(), 32'd0);
   endtask

   task automatic directedCase(input string tag, input logic [15:0] pc,
                               input logic [15:0] tgt, input bit jmp,
                               input logic [11:0] expField, input bit expAlign,
                               input bit expRange);
      int n;
      n = accepted;
      bif.out_ready = 1'b1;
      bif.pc        = pc;
      bif.target    = tgt;
      bif.jump      = jmp;
      bif.in_valid  = 1'b1;
      step();
      bif.in_valid = 1'b0;
      checkOutput({tag, "_accept"}, accepted - n, 32'd1);
      checkOutput({tag, "_lat1"}, bif.out_valid, 32'd0);
      step();
      checkOutput({tag, "_lat2"}, bif.out_valid, 32'd1);
      checkOutput({tag, "_field"}, bif.field, expField);
      checkOutput({tag, "_align"}, bif.err_align, expAlign);
      checkOutput({tag, "_range"}, bif.err_range, expRange);
      step();
   endtask

   initial begin
      logic [11:0] snapField;
      logic [15:0] rPc;
      logic [15:0] rTgt;
      bit          rJmp;
      int          span;
      int          off;
      int          n;

      bif.in_valid  = 1'b0;
      bif.out_ready = 1'b1;
      bif.pc        = '0;
      bif.target    = '0;
      bif.jump      = 1'b0;

      $display("[TB] reset");
      rst = 1'b1;
      step();
      step();
      checkOutput("rst_out_valid", bif.out_valid, 32'd0);
      checkOutput("rst_field", bif.field, 32'd0);
      checkOutput("rst_align", bif.err_align, 32'd0);
      checkOutput("rst_range", bif.err_range, 32'd0);
      checkOutput("rst_in_ready", bif.in_ready, 32'd0);
      rst = 1'b0;
      #1;
      checkOutput("post_rst_in_ready", bif.in_ready, 32'd1);

      $display("[TB] directed cases");
      directedCase("jump_700",   16'h0100, 16'h0F00, 1'b1, 12'h700, 1'b0, 1'b0);
      directedCase("br_max",     16'h0200, 16'h02FE, 1'b0, 12'h07F, 1'b0, 1'b0);
      directedCase("br_min",     16'h0200, 16'h0100, 1'b0, 12'h080, 1'b0, 1'b0);
      directedCase("br_over",    16'h0200, 16'h0300, 1'b0, 12'h080, 1'b0, 1'b1);
      checkOutput("cnt_after_range", bif.err_count, 32'd1);
      directedCase("odd",        16'h0010, 16'h0013, 1'b1, 12'h001, 1'b1, 1'b0);
      directedCase("wrap",       16'hFFFE, 16'h0002, 1'b0, 12'h002, 1'b0, 1'b0);
      checkOutput("cnt_after_dir", bif.err_count, 32'd2);

      $display("[TB] back-pressure");
      bif.out_ready = 1'b0;
      n = accepted;
      bif.in_valid = 1'b1;
      bif.pc = 16'h1000; bif.target = 16'h1010; bif.jump = 1'b0;
      step();
      bif.pc = 16'h2000; bif.target = 16'h1F00; bif.jump = 1'b1;
      step();
      checkOutput("bp_two_accepts", accepted - n, 32'd2);
      checkOutput("bp_in_ready_low", bif.in_ready, 32'd0);
      checkOutput("bp_out_valid", bif.out_valid, 32'd1);
      snapField = bif.field;
      bif.pc = 16'h3000; bif.target = 16'h3100; bif.jump = 1'b1;
      step();
      checkOutput("bp_hold_valid", bif.out_valid, 32'd1);
      checkOutput("bp_hold_field", bif.field, snapField);
      checkOutput("bp_still_two", accepted - n, 32'd2);
      bif.out_ready = 1'b1;
      applyStimulus(16'h3000, 16'h3100, 1'b1, 1'b0);
      applyStimulus(16'h4000, 16'h3FF0, 1'b0, 1'b0);
      drain();
      checkOutput("bp_four_accepts", accepted - n, 32'd4);

      $display("[TB] random traffic");
      for (int i = 0; i < 200; i++) begin
         rPc  = 16'($urandom);
         rJmp = $urandom_range(0, 1) != 0;
         span = rJmp ? 4096 : 256;
         off  = int'($urandom_range(0, 2 * span - 1)) - span;
         if ($urandom_range(0, 3) == 0) rTgt = 16'($urandom);
         else                           rTgt = rPc + 16'(off);
         applyStimulus(rPc, rTgt, rJmp, 1'b1);
         if ($urandom_range(0, 4) == 0) begin
            bif.in_valid = 1'b0;
            step();
         end
      end
      drain();

      $display("[TB] saturation");
      for (int i = 0; i < 300; i++) begin
         rPc = 16'($urandom);
         if (i % 2 == 0) applyStimulus(rPc, rPc + 16'h0003, 1'b1, 1'b0);
         else            applyStimulus(rPc, rPc + 16'h4000, 1'b0, 1'b0);
      end
      drain();
      checkOutput("err_count_sat", bif.err_count, 32'hFF);

      $display("[TB] reset with items in flight");
      applyStimulus(16'h0500, 16'h0510, 1'b0, 1'b0);
      applyStimulus(16'h0600, 16'h0620, 1'b1, 1'b0);
      bif.in_valid = 1'b0;
      rst = 1'b1;
      step();
      checkOutput("midrst_out_valid", bif.out_valid, 32'd0);
      checkOutput("midrst_err_count", bif.err_count, 32'd0);
      checkOutput("midrst_in_ready", bif.in_ready, 32'd0);
      rst = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         checkOutput("midrst_no_stale", bif.out_valid, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
